// File: rtl/tff_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tff_pkg
// Description : Shared definitions for the toggle-flop conditioning path:
//               debounce FSM state encodings, a sizing helper and the
//               simulation clock-to-output constant.
// Revision    : 1.0 - initial release
// ============================================================================
package tff_pkg;

  // Debounce FSM states; encodings are fixed so that waveforms and any
  // downstream decode stay stable across revisions.
  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    ARM_PRESS   = 2'd1,
    HELD        = 2'd2,
    ARM_RELEASE = 2'd3
  } state_t;

  // Simulation-only settle time used when sampling registered outputs.
  localparam int C2Q_DELAY = 1;

  // Larger of two integers; sizes counters shared by two limits.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage : tff_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchronizer for a single asynchronous input.
//               Resets to 0. Nothing sits ahead of the first flop so the
//               metastability window is confined to the first stage.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back capture flops; q is safe to use in the clk domain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule : sync_2ff
`default_nettype wire

// File: rtl/toggle_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module      : toggle_pulse_gen
// Description : Turns a raw bouncing push-button into one clean single-cycle
//               toggle request per confirmed press. Synchronizer, counter
//               based debounce FSM and press-edge pulse generator.
//               Optional macro AUTOREPEAT_EN: while the button stays held,
//               an extra pulse is issued every REPEAT_CYCLES cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module toggle_pulse_gen
  import tff_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_CYCLES   = 64,
  parameter int BTN_ACTIVE_HIGH = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_raw,
  output logic t_pulse,
  output logic btn_level,
  output logic busy
);

  // One width serves both counters; the compares fire before either wraps.
  localparam int              CNT_W    = $clog2(max_int(DEBOUNCE_CYCLES, REPEAT_CYCLES) + 1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic            INVERT   = (BTN_ACTIVE_HIGH == 0);

  logic             btn_sync;
  logic             btn_s;
  state_t           state;
  logic [CNT_W-1:0] cnt;

`ifdef AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_CYCLES - 1);
  logic [CNT_W-1:0] rpt_cnt;
`endif

  sync_2ff u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (btn_raw),
    .q       (btn_sync)
  );

  // Polarity is normalised after synchronisation so that btn_s=1 is "pressed".
  assign btn_s = btn_sync ^ INVERT;

  // Debounce FSM; every output is registered and updated with the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      t_pulse   <= 1'b0;
      btn_level <= 1'b0;
      busy      <= 1'b0;
`ifdef AUTOREPEAT_EN
      rpt_cnt   <= '0;
`endif
    end else begin
      t_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (btn_s) begin
            state <= ARM_PRESS;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end

        ARM_PRESS: begin
          if (!btn_s) begin
            // Bounce: abandon the qualification without a pulse.
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt == DEB_LAST) begin
            state     <= HELD;
            cnt       <= '0;
            t_pulse   <= 1'b1;
            btn_level <= 1'b1;
            busy      <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        HELD: begin
          if (!btn_s) begin
            state <= ARM_RELEASE;
            cnt   <= '0;
            busy  <= 1'b1;
          end
`ifdef AUTOREPEAT_EN
          else if (rpt_cnt == RPT_LAST) begin
            t_pulse <= 1'b1;
            rpt_cnt <= '0;
          end else begin
            rpt_cnt <= rpt_cnt + 1'b1;
          end
`endif
        end

        ARM_RELEASE: begin
          if (btn_s) begin
            // Release bounce: back to HELD, repeat phase kept intact.
            state <= HELD;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt == DEB_LAST) begin
            state     <= IDLE;
            cnt       <= '0;
            btn_level <= 1'b0;
            busy      <= 1'b0;
`ifdef AUTOREPEAT_EN
            rpt_cnt   <= '0;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule : toggle_pulse_gen
`default_nettype wire
